z_1_2_stream_demux: RTL and testbench

Z_1_2_STREAM_DEMUX -- requirements
Module: z_1_2_stream_demux

---
 rtl/z_1_2_stream_demux.sv | 104 ++++++++++
 tb/tb_z_1_2_stream_demux.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/z_1_2_stream_demux.sv
// One-to-two stream demultiplexer: each output port has its own 2-entry FIFO,
// so a stalled port only blocks words routed to it.
module z_1_2_stream_demux #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_sel,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] a_data,
  output logic             a_valid,
  input  logic             a_ready,
  output logic [WIDTH-1:0] b_data,
  output logic             b_valid,
  input  logic             b_ready,
  output logic [7:0]       a_cnt,
  output logic [7:0]       b_cnt
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } fifo_state_e;

  // Index 0 is port a, index 1 is port b.
  fifo_state_e      state_q [2];
  fifo_state_e      state_d [2];
  logic [WIDTH-1:0] head_q  [2];
  logic [WIDTH-1:0] head_d  [2];
  logic [WIDTH-1:0] tail_q  [2];
  logic [WIDTH-1:0] tail_d  [2];
  logic [7:0]       cnt_q   [2];
  logic [7:0]       cnt_d   [2];
  logic [1:0]       pushEn;
  logic [1:0]       popEn;
  logic [1:0]       outReady;

  // Readiness looks only at registered state, so a same-cycle pop never frees a FULL FIFO.
  assign in_ready = in_sel ? (state_q[1] != FULL) : (state_q[0] != FULL);
  assign pushEn   = {in_valid & in_ready & in_sel, in_valid & in_ready & ~in_sel};
  assign outReady = {b_ready, a_ready};

  always_comb begin
    for (int p = 0; p < 2; p++) begin
      state_d[p] = state_q[p];
      head_d[p]  = head_q[p];
      tail_d[p]  = tail_q[p];
      cnt_d[p]   = pushEn[p] ? cnt_q[p] + 8'd1 : cnt_q[p];
      popEn[p]   = (state_q[p] != EMPTY) & outReady[p];
      unique case (state_q[p])
        EMPTY: begin
          if (pushEn[p]) begin
            state_d[p] = ONE;
            head_d[p]  = in_data;
          end
        end
        ONE: begin
          if (pushEn[p] && popEn[p]) begin
            head_d[p] = in_data;
          end else if (pushEn[p]) begin
            state_d[p] = FULL;
            tail_d[p]  = in_data;
          end else if (popEn[p]) begin
            state_d[p] = EMPTY;
          end
        end
        FULL: begin
          if (popEn[p]) begin
            state_d[p] = ONE;
            head_d[p]  = tail_q[p];
          end
        end
        default: state_d[p] = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    for (int p = 0; p < 2; p++) begin
      if (!rst_) begin
        state_q[p] <= EMPTY;
        head_q[p]  <= '0;
        tail_q[p]  <= '0;
        cnt_q[p]   <= 8'd0;
      end else begin
        state_q[p] <= state_d[p];
        head_q[p]  <= head_d[p];
        tail_q[p]  <= tail_d[p];
        cnt_q[p]   <= cnt_d[p];
      end
    end
  end

  assign a_valid = (state_q[0] != EMPTY);
  assign b_valid = (state_q[1] != EMPTY);
  assign a_data  = a_valid ? head_q[0] : '0;
  assign b_data  = b_valid ? head_q[1] : '0;
  assign a_cnt   = cnt_q[0];
  assign b_cnt   = cnt_q[1];

endmodule

// File: tb/tb_z_1_2_stream_demux.sv
// Directed bench for z_1_2_stream_demux: inputs change and outputs are checked
// 1 time unit after each rising edge.
module tb_z_1_2_stream_demux;

  logic       clk = 1'b0;
  logic       rst_;
  logic [7:0] in_data;
  logic       in_sel;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] a_data;
  logic       a_valid;
  logic       a_ready;
  logic [7:0] b_data;
  logic       b_valid;
  logic       b_ready;
  logic [7:0] a_cnt;
  logic [7:0] b_cnt;

  int total = 0;
  int bad   = 0;

  z_1_2_stream_demux #(.WIDTH(8)) dut (
    .clk      (clk),
    .rst_     (rst_),
    .in_data  (in_data),
    .in_sel   (in_sel),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a_data   (a_data),
    .a_valid  (a_valid),
    .a_ready  (a_ready),
    .b_data   (b_data),
    .b_valid  (b_valid),
    .b_ready  (b_ready),
    .a_cnt    (a_cnt),
    .b_cnt    (b_cnt)
  );

  always #5 clk = ~clk;

  task automatic applyStimulus(input logic v, input logic s, input logic [7:0] d,
                               input logic ar, input logic br);
    in_valid = v;
    in_sel   = s;
    in_data  = d;
    a_ready  = ar;
    b_ready  = br;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    total++;
    assert (observed === expected)
    else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  initial begin
    rst_ = 1'b0;
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    tick();
    tick();

    // Reset state
    checkOutput("rst_a_valid", a_valid, 0);
    checkOutput("rst_b_valid", b_valid, 0);
    checkOutput("rst_a_data", a_data, 0);
    checkOutput("rst_b_data", b_data, 0);
    checkOutput("rst_in_ready_a", in_ready, 1);
    checkOutput("rst_a_cnt", a_cnt, 0);
    checkOutput("rst_b_cnt", b_cnt, 0);
    applyStimulus(1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
    checkOutput("rst_in_ready_b", in_ready, 1);

    // Single word through port a
    rst_ = 1'b1;
    applyStimulus(1'b1, 1'b0, 8'h5A, 1'b1, 1'b0);
    checkOutput("single_in_ready", in_ready, 1);
    tick();
    applyStimulus(1'b0, 1'b1, 8'hEE, 1'b1, 1'b0);
    checkOutput("single_a_valid", a_valid, 1);
    checkOutput("single_a_data", a_data, 8'h5A);
    checkOutput("single_b_valid", b_valid, 0);
    checkOutput("single_a_cnt", a_cnt, 1);
    tick();
    checkOutput("single_a_drained", a_valid, 0);
    checkOutput("single_a_data_zero", a_data, 0);
    checkOutput("ignored_b_cnt", b_cnt, 0);

    // Fill port a with backpressure, then drain
    applyStimulus(1'b1, 1'b0, 8'h11, 1'b0, 1'b0);
    checkOutput("fill_rdy_11", in_ready, 1);
    tick();
    applyStimulus(1'b1, 1'b0, 8'h22, 1'b0, 1'b0);
    checkOutput("fill_rdy_22", in_ready, 1);
    tick();
    applyStimulus(1'b1, 1'b0, 8'h33, 1'b0, 1'b0);
    checkOutput("fill_rdy_33_stall", in_ready, 0);
    tick();
    checkOutput("fill_head_11", a_data, 8'h11);
    checkOutput("fill_a_cnt", a_cnt, 3);
    applyStimulus(1'b1, 1'b0, 8'h33, 1'b1, 1'b0);
    checkOutput("full_pop_not_ready", in_ready, 0);
    tick();
    checkOutput("drain_head_22", a_data, 8'h22);
    checkOutput("drain_rdy_one", in_ready, 1);
    tick();
    checkOutput("drain_head_33", a_data, 8'h33);
    checkOutput("drain_a_valid", a_valid, 1);
    checkOutput("drain_a_cnt", a_cnt, 4);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    tick();
    checkOutput("drain_empty", a_valid, 0);

    // Port a full does not block port b
    applyStimulus(1'b1, 1'b0, 8'hAA, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b1, 1'b0, 8'hBB, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b1, 1'b0, 8'hCC, 1'b0, 1'b0);
    checkOutput("a_full_rdy", in_ready, 0);
    applyStimulus(1'b1, 1'b1, 8'h44, 1'b0, 1'b0);
    checkOutput("b_rdy_while_a_full", in_ready, 1);
    tick();
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    checkOutput("indep_b_valid", b_valid, 1);
    checkOutput("indep_b_data", b_data, 8'h44);
    checkOutput("indep_a_head", a_data, 8'hAA);
    checkOutput("indep_a_cnt", a_cnt, 6);
    checkOutput("indep_b_cnt", b_cnt, 1);

    // Simultaneous push and pop on port b in ONE
    applyStimulus(1'b0, 1'b1, 8'h00, 1'b0, 1'b1);
    tick();
    checkOutput("b_drained", b_valid, 0);
    applyStimulus(1'b1, 1'b1, 8'h01, 1'b0, 1'b0);
    tick();
    checkOutput("b_one_head_01", b_data, 8'h01);
    applyStimulus(1'b1, 1'b1, 8'h02, 1'b0, 1'b1);
    tick();
    checkOutput("pushpop_b_data", b_data, 8'h02);
    checkOutput("pushpop_b_valid", b_valid, 1);
    checkOutput("pushpop_b_cnt", b_cnt, 3);
    applyStimulus(1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
    checkOutput("pushpop_still_one", in_ready, 1);
    tick();
    checkOutput("pushpop_hold", b_data, 8'h02);
    checkOutput("pushpop_a_untouched", a_data, 8'hAA);

    // Reset mid-operation, with push and pop attempted
    rst_ = 1'b0;
    applyStimulus(1'b1, 1'b1, 8'h77, 1'b1, 1'b1);
    tick();
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    checkOutput("midrst_a_valid", a_valid, 0);
    checkOutput("midrst_b_valid", b_valid, 0);
    checkOutput("midrst_a_data", a_data, 0);
    checkOutput("midrst_b_data", b_data, 0);
    checkOutput("midrst_a_cnt", a_cnt, 0);
    checkOutput("midrst_b_cnt", b_cnt, 0);
    checkOutput("midrst_in_ready", in_ready, 1);
    rst_ = 1'b1;
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
    tick();
    checkOutput("postrst_a_valid", a_valid, 0);
    checkOutput("postrst_b_valid", b_valid, 0);
    tick();
    checkOutput("postrst2_a_valid", a_valid, 0);
    checkOutput("postrst2_b_valid", b_valid, 0);

    // 256 words through port b: order preserved and counter wraps
    for (int i = 0; i < 256; i++) begin
      applyStimulus(1'b1, 1'b1, 8'(i ^ 8'h5C), 1'b1, 1'b1);
      tick();
      checkOutput($sformatf("wrap_b_data_%0d", i), {b_valid, b_data}, {1'b1, 8'(i ^ 8'h5C)});
    end
    checkOutput("wrap_b_cnt", b_cnt, 0);
    checkOutput("wrap_a_cnt", a_cnt, 0);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
    tick();
    checkOutput("wrap_b_empty", b_valid, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
